// File: rtl/vector_to_angle.sv
// Maps a signed (DX, DY) vector to the nearest of 45 heading indices (8 deg steps)
// by scanning the sinCos direction table and keeping the index with the largest dot product.
module vector_to_angle #(
  parameter int VEC_W = 10,
  parameter int ACC_W = 18
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Start,
  input  logic signed [VEC_W-1:0] DX,
  input  logic signed [VEC_W-1:0] DY,
  output logic                    Busy,
  output logic                    Done,
  output logic [5:0]              AngleO
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  localparam logic [5:0] LAST_IDX = 6'd44;

  logic [0:0]              state;
  logic [5:0]              idx;
  logic [5:0]              bestIdx;
  logic signed [ACC_W-1:0] best;
  logic signed [VEC_W-1:0] dxR;
  logic signed [VEC_W-1:0] dyR;
  logic [4:0]              cosMag;
  logic [4:0]              sinMag;
  logic signed [5:0]       cosTerm;
  logic signed [5:0]       sinTerm;
  logic signed [ACC_W-1:0] dot;
  logic                    takeIdx;

  function automatic logic signed [ACC_W-1:0] dotTerm(
    input logic signed [5:0]       c,
    input logic signed [5:0]       s,
    input logic signed [VEC_W-1:0] x,
    input logic signed [VEC_W-1:0] y
  );
    logic signed [VEC_W+5:0] pc;
    logic signed [VEC_W+5:0] ps;
    pc = (VEC_W+6)'(c) * (VEC_W+6)'(x);
    ps = (VEC_W+6)'(s) * (VEC_W+6)'(y);
    return ACC_W'(pc) + ACC_W'(ps);
  endfunction

  sinCos uTable (
    .Angle  (idx),
    .CosMag (cosMag),
    .SinMag (sinMag)
  );

  // Table holds magnitudes only; quadrant signs are restored from the index.
  always_comb begin
    cosTerm = $signed({1'b0, cosMag});
    sinTerm = $signed({1'b0, sinMag});
    if (idx >= 6'd12 && idx <= 6'd33) cosTerm = -$signed({1'b0, cosMag});
    if (idx >= 6'd23)                 sinTerm = -$signed({1'b0, sinMag});
    dot     = dotTerm(cosTerm, sinTerm, dxR, dyR);
    takeIdx = (idx == 6'd0) || (dot > best);
  end

  assign Busy = (state == SCAN);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      Done    <= 1'b0;
      AngleO  <= 6'd0;
      idx     <= 6'd0;
      bestIdx <= 6'd0;
      best    <= '0;
      dxR     <= '0;
      dyR     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            dxR   <= DX;
            dyR   <= DY;
            idx   <= 6'd0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (takeIdx) begin
            best    <= dot;
            bestIdx <= idx;
          end
          // The last candidate must be folded in combinationally, its register update lands too late.
          if (idx == LAST_IDX) begin
            AngleO <= takeIdx ? idx : bestIdx;
            Done   <= 1'b1;
            state  <= IDLE;
            idx    <= 6'd0;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// Direction table: round(16*|cos|) and round(16*|sin|) for angle index * 8 deg.
module sinCos (
  input  logic [5:0] Angle,
  output logic [4:0] CosMag,
  output logic [4:0] SinMag
);

  logic [9:0] cs;

  always_comb begin
    case (Angle)
      6'd0:  cs = {5'd16, 5'd0};
      6'd1:  cs = {5'd16, 5'd2};
      6'd2:  cs = {5'd15, 5'd4};
      6'd3:  cs = {5'd15, 5'd7};
      6'd4:  cs = {5'd14, 5'd8};
      6'd5:  cs = {5'd12, 5'd10};
      6'd6:  cs = {5'd11, 5'd12};
      6'd7:  cs = {5'd9,  5'd13};
      6'd8:  cs = {5'd7,  5'd14};
      6'd9:  cs = {5'd5,  5'd15};
      6'd10: cs = {5'd3,  5'd16};
      6'd11: cs = {5'd1,  5'd16};
      6'd12: cs = {5'd2,  5'd16};
      6'd13: cs = {5'd4,  5'd16};
      6'd14: cs = {5'd6,  5'd15};
      6'd15: cs = {5'd8,  5'd14};
      6'd16: cs = {5'd10, 5'd13};
      6'd17: cs = {5'd12, 5'd11};
      6'd18: cs = {5'd13, 5'd9};
      6'd19: cs = {5'd14, 5'd8};
      6'd20: cs = {5'd15, 5'd5};
      6'd21: cs = {5'd16, 5'd3};
      6'd22: cs = {5'd16, 5'd1};
      6'd23: cs = {5'd16, 5'd1};
      6'd24: cs = {5'd16, 5'd3};
      6'd25: cs = {5'd15, 5'd5};
      6'd26: cs = {5'd14, 5'd8};
      6'd27: cs = {5'd13, 5'd9};
      6'd28: cs = {5'd12, 5'd11};
      6'd29: cs = {5'd10, 5'd13};
      6'd30: cs = {5'd8,  5'd14};
      6'd31: cs = {5'd6,  5'd15};
      6'd32: cs = {5'd4,  5'd16};
      6'd33: cs = {5'd2,  5'd16};
      6'd34: cs = {5'd1,  5'd16};
      6'd35: cs = {5'd3,  5'd16};
      6'd36: cs = {5'd5,  5'd15};
      6'd37: cs = {5'd7,  5'd14};
      6'd38: cs = {5'd9,  5'd13};
      6'd39: cs = {5'd11, 5'd12};
      6'd40: cs = {5'd12, 5'd10};
      6'd41: cs = {5'd14, 5'd8};
      6'd42: cs = {5'd15, 5'd7};
      6'd43: cs = {5'd15, 5'd4};
      6'd44: cs = {5'd16, 5'd2};
      default: cs = 10'd0;
    endcase
    CosMag = cs[9:5];
    SinMag = cs[4:0];
  end

endmodule
